// File: rtl/vga_pkg.sv
// Shared RGB565 field layout, sequencer counter widths and FSM state encoding
// for the pattern sequencer and its blender.
package vga_pkg;
  localparam int RGB_W   = 16;
  localparam int R_W     = 5;
  localparam int G_W     = 6;
  localparam int B_W     = 5;
  localparam int R_LSB   = 11;
  localparam int G_LSB   = 5;
  localparam int B_LSB   = 0;

  localparam int IDX_W   = 3;
  localparam int HOLD_W  = 10;
  localparam int WGT_W   = 6;
  localparam int MAX_PAT = 8;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_FADE = 1'b1
  } seq_state_e;

  // Extract one colour field, zero-extended to the widest channel (green).
  function automatic logic [G_W-1:0] chan(input logic [RGB_W-1:0] px,
                                          input int lsb, input int w);
    return G_W'(px >> lsb) & G_W'((1 << w) - 1);
  endfunction
endpackage

// File: rtl/pattern_sequencer_if.sv
// Pattern sequencer bus: frame/control inputs, source pixels and the
// registered colour/index/fade outputs.
interface pattern_sequencer_if
  import vga_pkg::*;
#(
  parameter int N_PAT = 4
) ();
  logic                   i_frame;
  logic [RGB_W*N_PAT-1:0] i_pat_rgb;
  logic                   i_auto;
  logic                   i_next;
  logic                   i_pause;
  logic [R_W-1:0]         o_R;
  logic [G_W-1:0]         o_G;
  logic [B_W-1:0]         o_B;
  logic [IDX_W-1:0]       o_pat_idx;
  logic                   o_fading;

  modport master (
    output i_frame, i_pat_rgb, i_auto, i_next, i_pause,
    input  o_R, o_G, o_B, o_pat_idx, o_fading
  );

  modport slave (
    input  i_frame, i_pat_rgb, i_auto, i_next, i_pause,
    output o_R, o_G, o_B, o_pat_idx, o_fading
  );
endinterface

// File: rtl/rgb_blend.sv
// Combinational RGB565 crossfade: out = (a*(F-w) + b*w) >> FADE_SHIFT per
// channel, truncating, with F = 2**FADE_SHIFT.
module rgb_blend
  import vga_pkg::*;
#(
  parameter int FADE_SHIFT = 4
) (
  input  logic [RGB_W-1:0] i_a,
  input  logic [RGB_W-1:0] i_b,
  input  logic [WGT_W-1:0] i_w,
  output logic [RGB_W-1:0] o_rgb
);
  localparam int PW       = G_W + FADE_SHIFT + 1;
  localparam int FADE_LEN = 1 << FADE_SHIFT;

  // The weighted sum never exceeds 63*F, so PW bits hold it without overflow.
  function automatic logic [G_W-1:0] mix(input logic [G_W-1:0]   c0,
                                         input logic [G_W-1:0]   c1,
                                         input logic [WGT_W-1:0] w);
    logic [PW-1:0] wb;
    logic [PW-1:0] wa;
    logic [PW-1:0] acc;
    wb  = PW'(w);
    wa  = PW'(FADE_LEN) - wb;
    acc = PW'(c0) * wa + PW'(c1) * wb;
    return G_W'(acc >> FADE_SHIFT);
  endfunction

  assign o_rgb[R_LSB +: R_W] = R_W'(mix(chan(i_a, R_LSB, R_W), chan(i_b, R_LSB, R_W), i_w));
  assign o_rgb[G_LSB +: G_W] = G_W'(mix(chan(i_a, G_LSB, G_W), chan(i_b, G_LSB, G_W), i_w));
  assign o_rgb[B_LSB +: B_W] = B_W'(mix(chan(i_a, B_LSB, B_W), chan(i_b, B_LSB, B_W), i_w));
endmodule

// File: rtl/pattern_sequencer.sv
// Cycles through N_PAT RGB565 sources, holding each for HOLD_FRAMES frames and
// optionally crossfading into the next over 2**FADE_SHIFT frames.
module pattern_sequencer
  import vga_pkg::*;
#(
  parameter int N_PAT       = 4,
  parameter int HOLD_FRAMES = 480,
  parameter int FADE_SHIFT  = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  pattern_sequencer_if.slave bus
);
  localparam int FADE_LEN = 1 << FADE_SHIFT;

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WGT_W-1:0]  w_q, w_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              fading_q, fading_d;

  logic [MAX_PAT*RGB_W-1:0] pat_pad;
  logic [IDX_W-1:0]         nxt_idx;
  logic [RGB_W-1:0]         src_cur;
  logic [RGB_W-1:0]         src_nxt;
  logic [RGB_W-1:0]         blend_rgb;
  logic                     hold_last;
  logic                     w_last;
  logic                     adv;

  // Padding to eight sources lets a 3-bit index select a slice without range checks.
  assign pat_pad   = (MAX_PAT*RGB_W)'(bus.i_pat_rgb);
  assign nxt_idx   = (cur_q == IDX_W'(N_PAT - 1)) ? '0 : cur_q + IDX_W'(1);
  assign src_cur   = pat_pad[{cur_q, 4'b0000} +: RGB_W];
  assign src_nxt   = pat_pad[{nxt_idx, 4'b0000} +: RGB_W];
  assign hold_last = (hold_q == HOLD_W'(HOLD_FRAMES - 1));
  assign w_last    = (w_q == WGT_W'(FADE_LEN - 1));

  rgb_blend #(
    .FADE_SHIFT(FADE_SHIFT)
  ) u_blend (
    .i_a  (src_cur),
    .i_b  (src_nxt),
    .i_w  (w_q),
    .o_rgb(blend_rgb)
  );

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    hold_d   = hold_q;
    w_d      = w_q;
    adv      = 1'b0;
    unique case (state_q)
      ST_HOLD: begin
        // A manual request pre-empts a coincident frame tick: one advance only.
        if (bus.i_next) begin
          hold_d = '0;
          adv    = 1'b1;
        end else if (bus.i_frame && bus.i_auto && !bus.i_pause) begin
          if (hold_last) begin
            hold_d = '0;
            adv    = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        if (adv) begin
          if (FADE_SHIFT == 0) begin
            cur_d = nxt_idx;
          end else begin
            state_d = ST_FADE;
            w_d     = '0;
          end
        end
      end
      ST_FADE: begin
        if (bus.i_next || (bus.i_frame && !bus.i_pause && w_last)) begin
          cur_d   = nxt_idx;
          w_d     = '0;
          hold_d  = '0;
          state_d = ST_HOLD;
        end else if (bus.i_frame && !bus.i_pause) begin
          w_d = w_q + WGT_W'(1);
        end
      end
      default: state_d = ST_HOLD;
    endcase
    rgb_d    = blend_rgb;
    idx_d    = cur_q;
    fading_d = (state_q == ST_FADE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_HOLD;
      cur_q    <= '0;
      hold_q   <= '0;
      w_q      <= '0;
      rgb_q    <= '0;
      idx_q    <= '0;
      fading_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      hold_q   <= hold_d;
      w_q      <= w_d;
      rgb_q    <= rgb_d;
      idx_q    <= idx_d;
      fading_q <= fading_d;
    end
  end

  assign bus.o_R       = rgb_q[R_LSB +: R_W];
  assign bus.o_G       = rgb_q[G_LSB +: G_W];
  assign bus.o_B       = rgb_q[B_LSB +: B_W];
  assign bus.o_pat_idx = idx_q;
  assign bus.o_fading  = fading_q;
endmodule
